// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-banked sprite line buffer with a 2-stage RMW merge write path,
// a registered composer read port and a background erase sweep of the display bank.
module sprite_line_buffer #(
    parameter int DEPTH = 640,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_render_start,
    input  logic             erase_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_data,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [15:0]      rd_data,
    output logic [3:0]       collisions,
    input  logic             collisions_clr,
    output logic             erase_busy
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e           state_q, state_d;
    logic             bank_sel_q, bank_sel_d;
    logic             erase_bank_q, erase_bank_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic [3:0]       coll_q, coll_d;
    logic             s1_v_q, s1_bank_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [15:0]      s1_new_q, s1_old_q;
    logic [15:0]      mem [2][DEPTH];
    logic             s0_acc, fwd;
    logic [15:0]      merged, s0_old;
    logic [3:0]       hit;

    always_comb begin
        merged = (s1_old_q[7:0] == 8'd0)
               ? {s1_old_q[15:12] | s1_new_q[15:12], 2'b00, s1_new_q[9:0]}
               : {s1_old_q[15:12] | s1_new_q[15:12], 2'b00, s1_old_q[9:0]};
        hit = (s1_old_q[7:0] != 8'd0) ? (s1_old_q[15:12] & s1_new_q[15:12]) : 4'd0;
        wr_ready = !(state_q == SWEEP && erase_bank_q == bank_sel_q);
        s0_acc = wr_en && wr_ready && wr_idx <= LAST && wr_data[7:0] != 8'd0;
        // S1 writes back on this same edge, so its merged value is the true old entry
        fwd = s1_v_q && s1_bank_q == bank_sel_q && s1_idx_q == wr_idx;
        s0_old = fwd ? merged : mem[bank_sel_q][wr_idx];
        rd_data_d = (rd_idx <= LAST) ? mem[!bank_sel_q][rd_idx] : 16'd0;
        bank_sel_d = bank_sel_q ^ line_render_start;
        coll_d = collisions_clr ? 4'd0 : (coll_q | (s1_v_q ? hit : 4'd0));
        state_d = state_q;
        erase_bank_d = erase_bank_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (erase_start) begin
                state_d = SWEEP;
                erase_bank_d = !bank_sel_q;
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bank_sel_q   <= 1'b0;
            erase_bank_q <= 1'b0;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            coll_q       <= '0;
            s1_v_q       <= 1'b0;
            s1_bank_q    <= 1'b0;
            s1_idx_q     <= '0;
            s1_new_q     <= '0;
            s1_old_q     <= '0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            erase_bank_q <= erase_bank_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            coll_q       <= coll_d;
            s1_v_q       <= s0_acc;
            s1_bank_q    <= bank_sel_q;
            s1_idx_q     <= wr_idx;
            s1_new_q     <= wr_data;
            s1_old_q     <= s0_old;
        end
    end

    // Sweep and writeback never share a bank: writes stall while the sweep owns the render bank
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) mem[erase_bank_q][cnt_q] <= 16'd0;
        if (s1_v_q) mem[s1_bank_q][s1_idx_q] <= merged;
    end

    assign rd_data    = rd_data_q;
    assign collisions = coll_q;
    assign erase_busy = (state_q == SWEEP);
endmodule
